// File: rtl/core_mgmt_axi_master.sv
// core_mgmt_axi_master: per-core AXI-lite master.
// It turns one single-beat CPU register request (valid/ready, we, addr, wdata,
// wstrb) into one AXI-lite write or read. Only one transaction is in flight at
// a time. The result is returned as a one-cycle resp_valid pulse with rdata/err.
//
// Optional build macro CORE_MGMT_TIMEOUT_EN adds a watchdog. The watchdog
// abandons a transaction after TIMEOUT_CYCLES busy cycles and reports resp_err.
// Without the macro, the block waits indefinitely for the slave.
//
// Handshake semantics (all channels): a transfer happens on the rising clk edge
// where valid && ready are both high. A valid, once raised, stays high and keeps
// its payload stable until that edge, and it drops in the following cycle.
// Every AXI output is a flop, so no AXI input reaches an AXI output
// combinationally.
module core_mgmt_axi_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    // core request / response
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    // AXI-lite write address / data / response
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    // AXI-lite read address / data
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    // debug: current FSM state
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t              state_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                aw_done_q, w_done_q;
    logic                aw_done_d, w_done_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                resp_valid_q, resp_err_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic tmo_hit;

    // Only the error bit of each response code matters here.
    logic unused_resp_lsb;
    assign unused_resp_lsb = bresp[0] ^ rresp[0];

    assign aw_hs = awvalid_q && awready;
    assign w_hs  = wvalid_q  && wready;
    assign b_hs  = bready_q  && bvalid;
    assign ar_hs = arvalid_q && arready;
    assign r_hs  = rready_q  && rvalid;

    // A channel counts as done once it has handshaked, either earlier or in
    // this cycle.
    assign aw_done_d = aw_done_q || aw_hs;
    assign w_done_d  = w_done_q  || w_hs;

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = resp_err_q;
    assign awvalid     = awvalid_q;
    assign awaddr      = addr_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign bready      = bready_q;
    assign arvalid     = arvalid_q;
    assign araddr      = addr_q;
    assign rready      = rready_q;
    assign dbg_state_o = state_q;

`ifdef CORE_MGMT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             busy;
    logic             finishing;

    assign busy      = state_q inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA};
    // A final handshake in the last allowed cycle still completes normally.
    assign finishing = (state_q == S_WR_RESP && b_hs) || (state_q == S_RD_DATA && r_hs);
    assign tmo_hit   = busy && !finishing && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: count busy cycles; idle and response cycles clear it.
    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (req_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= S_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end
                S_WR: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (b_hs) begin
                        bready_q     <= 1'b0;
                        resp_err_q   <= bresp[1];
                        rdata_q      <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (r_hs) begin
                        rready_q     <= 1'b0;
                        rdata_q      <= rdata;
                        resp_err_q   <= rresp[1];
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Watchdog expiry overrides whatever the busy state was doing.
            if (tmo_hit) begin
                awvalid_q    <= 1'b0;
                wvalid_q     <= 1'b0;
                bready_q     <= 1'b0;
                arvalid_q    <= 1'b0;
                rready_q     <= 1'b0;
                aw_done_q    <= 1'b0;
                w_done_q     <= 1'b0;
                rdata_q      <= '0;
                resp_err_q   <= 1'b1;
                resp_valid_q <= 1'b1;
                state_q      <= S_RESP;
            end
        end
    end

endmodule

// File: tb/tb_core_mgmt_axi_master.sv
// Bench for core_mgmt_axi_master: directed latency/skew/error/reset cases plus
// randomized traffic against a word-array reference model and an AXI-lite slave.
module tb_core_mgmt_axi_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [2:0]    dbg_state;

  core_mgmt_axi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Expected response entry: {err, rdata}.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem[16];
  logic          slave_hangs = 1'b0;
  logic          tmo_test    = 1'b0;

  // Register map seen by the model: addr[5:2] selects one of 16 words,
  // addr[6] set means the slave answers SLVERR (no effect, read data 0).
  function automatic void model_push(input logic we, input logic [AW-1:0] addr,
                                     input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int idx;
    idx = int'(addr[5:2]);
    if (slave_hangs) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
    end else if (we) begin
      if (!addr[6])
        for (int b = 0; b < SW; b++)
          if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      exp_q.push_back({addr[6], {DW{1'b0}}});
    end else begin
      exp_q.push_back({addr[6], addr[6] ? {DW{1'b0}} : ref_mem[idx]});
    end
  endfunction

  // ---------------- AXI-lite slave + protocol monitor ----------------
  int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic          sl_aw_got, sl_w_got, b_pend, r_pend;
  logic [AW-1:0] sl_awaddr, sl_araddr, sl_awaddr_last;
  logic [DW-1:0] sl_wdata, sl_wdata_last;
  logic [SW-1:0] sl_wstrb;
  logic [DW-1:0] sl_mem[16];
  int            aw_hi_cnt, w_hi_cnt;
  logic [DW-1:0] last_rdata;
  logic          p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic          p_arvalid, p_arready, p_rvalid, p_rready, p_resp_valid;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      sl_mem[i]  = '0;
    end
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    sl_aw_got = 0; sl_w_got = 0; b_pend = 0; r_pend = 0;
    sl_awaddr = 0; sl_araddr = 0; sl_awaddr_last = 0; sl_wdata = 0; sl_wdata_last = 0; sl_wstrb = 0;
    aw_hi_cnt = 0; w_hi_cnt = 0; last_rdata = 0;
    p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_bvalid = 0; p_bready = 0;
    p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0; p_resp_valid = 0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        sl_aw_got = 0; sl_w_got = 0; b_pend = 0; r_pend = 0;
        last_rdata = 0;
      end else begin
        // scoreboard
        if (resp_valid) begin
          resp_cnt++;
          if (exp_q.size() == 0) begin
            check("resp_unexpected", resp_valid, 1'b0);
          end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("resp_err", resp_err, e[DW]);
            check("resp_rdata", resp_rdata, e[DW-1:0]);
            last_rdata = e[DW-1:0];
          end
        end else begin
          check("rdata_hold", resp_rdata, last_rdata);
        end
        if (p_resp_valid) check("resp_one_cycle", resp_valid, 1'b0);

        // protocol: valids hold with stable payload until handshake
        if (!tmo_test) begin
          if (p_awvalid && !p_awready) begin
            check("aw_hold", awvalid, 1'b1);
            check("awaddr_stable", awaddr, p_awaddr);
          end
          if (p_wvalid && !p_wready) begin
            check("w_hold", wvalid, 1'b1);
            check("wdata_stable", wdata, p_wdata);
            check("wstrb_stable", wstrb, p_wstrb);
          end
          if (p_arvalid && !p_arready) begin
            check("ar_hold", arvalid, 1'b1);
            check("araddr_stable", araddr, p_araddr);
          end
        end
        if (awvalid || wvalid) check("bready_early", bready, 1'b0);
        if (awvalid || wvalid || arvalid || bready || rready) check("req_ready_busy_mon", req_ready, 1'b0);
        if (awvalid) aw_hi_cnt++;
        if (wvalid)  w_hi_cnt++;

        // slave: handshakes that happened at the last rising edge
        if (p_awvalid && p_awready) begin
          sl_awaddr = p_awaddr; sl_awaddr_last = p_awaddr; sl_aw_got = 1;
        end
        if (p_wvalid && p_wready) begin
          sl_wdata = p_wdata; sl_wdata_last = p_wdata; sl_wstrb = p_wstrb; sl_w_got = 1;
        end
        if (p_bvalid && p_bready) bvalid = 0;
        if (p_arvalid && p_arready) begin
          sl_araddr = p_araddr; r_pend = 1; r_cnt = 0;
        end
        if (p_rvalid && p_rready) rvalid = 0;

        if (sl_aw_got && sl_w_got) begin
          if (!sl_awaddr[6])
            for (int b = 0; b < SW; b++)
              if (sl_wstrb[b]) sl_mem[sl_awaddr[5:2]][8*b +: 8] = sl_wdata[8*b +: 8];
          bresp = sl_awaddr[6] ? 2'b10 : 2'b00;
          sl_aw_got = 0; sl_w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (b_pend) begin
          if (b_cnt >= b_dly) begin bvalid = 1; b_pend = 0; end
          else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1;
            rresp  = sl_araddr[6] ? 2'b10 : 2'b00;
            rdata  = sl_araddr[6] ? '0 : sl_mem[sl_araddr[5:2]];
            r_pend = 0;
          end else r_cnt++;
        end

        // ready generation: zero delay means ready is held high
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        w_cnt  = wvalid  ? w_cnt + 1  : 0;
        ar_cnt = arvalid ? ar_cnt + 1 : 0;
        awready = (aw_dly == 0) || (awvalid && aw_cnt > aw_dly);
        wready  = (w_dly == 0)  || (wvalid && w_cnt > w_dly);
        arready = !slave_hangs && ((ar_dly == 0) || (arvalid && ar_cnt > ar_dly));
      end
      p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
      p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_bvalid = bvalid; p_bready = bready;
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
      p_rvalid = rvalid; p_rready = rready;
      p_resp_valid = rst ? 1'b0 : resp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    model_push(we, addr, data, strb);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    @(negedge clk);
    req_valid = 0;
  endtask

  // Latency counts falling edges from the request drive to the response pulse.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      check("req_ready_busy", req_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("resp_seen", resp_valid, 1'b1);
    @(negedge clk);
    check("ready_after_resp", req_ready, 1'b1);
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [SW-1:0] strb, output int lat);
    start_req(we, addr, data, strb);
    wait_resp(lat);
  endtask

  task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, rc;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_resp", {resp_valid, resp_err}, 2'b0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_addr", {awaddr, araddr}, 0);
    check("rst_wdata", {wdata, wstrb}, 0);
    rst = 0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);

    // write, always-ready slave
    set_dly(0, 0, 0, 0, 0);
    do_req(1'b1, 32'h1, 32'h1, 4'hF, lat);
    check("wr_min_latency", lat, 3);
    check("wr_awaddr", sl_awaddr_last, 32'h1);
    check("wr_wdata", sl_wdata_last, 32'h1);

    // write with W stalled three cycles
    set_dly(0, 3, 0, 0, 0);
    aw_hi_cnt = 0; w_hi_cnt = 0; rc = resp_cnt;
    do_req(1'b1, 32'h0, 32'h6, 4'hF, lat);
    check("skew_aw_cycles", aw_hi_cnt, 1);
    check("skew_w_cycles", w_hi_cnt, 4);
    check("skew_wdata", sl_wdata_last, 32'h6);
    check("skew_latency", lat, 6);
    check("skew_one_resp", resp_cnt - rc, 1);

    // read with AR and R delays
    set_dly(0, 0, 0, 1, 2);
    rc = resp_cnt;
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat);
    check("rd_latency", lat, 6);
    check("rd_one_resp", resp_cnt - rc, 1);

    // minimum read latency
    set_dly(0, 0, 0, 0, 0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, lat);
    check("rd_min_latency", lat, 3);

    // error write followed by clean read
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, lat);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat);

    // reset while waiting for read data
    set_dly(0, 0, 0, 0, 8);
    start_req(1'b0, 32'h0, 32'h0, 4'h0);
    lat = 0;
    while (!rready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rst_mid_rready_seen", rready, 1'b1);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_arvalid", arvalid, 1'b0);
    check("rst_mid_rready", rready, 1'b0);
    check("rst_mid_resp_valid", resp_valid, 1'b0);
    check("rst_mid_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_mid_ready_after", req_ready, 1'b1);
    set_dly(0, 0, 0, 0, 0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, lat);
    check("rst_mid_next_read_lat", lat, 3);

`ifdef CORE_MGMT_TIMEOUT_EN
    // slave never accepts the read address
    slave_hangs = 1; tmo_test = 1;
    do_req(1'b0, 32'h8, 32'h0, 4'h0, lat);
    check("tmo_latency_range", (lat >= TMO && lat <= TMO + 2), 1'b1);
    check("tmo_arvalid_dropped", arvalid, 1'b0);
    slave_hangs = 0; tmo_test = 0;
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic          we;
      logic [AW-1:0] addr;
      we   = 1'($urandom_range(0, 1));
      addr = '0;
      addr[6]   = ($urandom_range(0, 4) == 0);
      addr[5:2] = 4'($urandom_range(0, 15));
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      do_req(we, addr, $urandom, 4'($urandom_range(0, 15)), lat);
    end

    // read back every word
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] addr;
      addr = AW'(i * 4);
      set_dly(0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 2));
      do_req(1'b0, addr, 32'h0, 4'h0, lat);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
